parity_frame_chk: RTL and testbench
===================================

# parity_frame_chk

Serial framed parity checker, parametrised successor to the single-bit parity FSM. It accepts a qualified serial bit stream of DATA_W data bits followed by one parity bit per frame. Each frame is checked against a per-frame even/odd mode. It reports a running parity, a frame-done pulse, an error pulse, a sticky error flag and a saturating error count. It sits behind a serial receiver and feeds status/CSR logic.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (≥1); parity bit follows as bit DATA_W+1
- CNT_W, 8, error counter width (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- x  in  1  serial data/parity bit
- x_valid  in  1  x qualifier; bit accepted on rising clk when high
- odd  in  1  parity mode, 1 = odd, 0 = even; sampled on first data bit of frame
- clr  in  1  synchronous clear of err_sticky and err_cnt
- z  out  1  running XOR of data bits accepted in current frame
- busy  out  1  frame in progress (state ≠ IDLE)
- frame_done  out  1  one-cycle pulse, frame complete
- par_err  out  1  one-cycle pulse with frame_done on parity mismatch
- err_sticky  out  1  set by any parity error, cleared by clr
- err_cnt  out  CNT_W  saturating count of parity errors

## Operation
- Registers: state, bit counter (width $clog2(DATA_W+1)), acc (running parity), mode (latched odd).
- States:
  - IDLE: no bits of the current frame received.
  - DATA: data bits are being received.
  - PAR: the next accepted bit is the parity bit.
- When x_valid = 0, all state holds.
- IDLE + valid: acc←x, mode←odd, cnt←1; next state PAR if DATA_W = 1, else DATA.
- DATA + valid: acc←acc^x, cnt←cnt+1; next state PAR when the accepted bit is bit DATA_W.
- PAR + valid:
  - Expected parity bit = acc ^ mode.
  - Mismatch → par_err.
  - frame_done is asserted; acc←0, cnt←0, next state IDLE.
- z = acc, so z is 0 in IDLE.
- odd changes after the first data bit are ignored until the next frame.
- Error accounting on a par_err event:
  - err_sticky←1.
  - err_cnt←err_cnt+1, saturating at 2^CNT_W−1.
- clr in the same cycle as an error event: the clear applies first, then the error. Result: err_sticky = 1, err_cnt = 1.
- Reset (reset = 0, any time, including mid-frame): state IDLE, cnt/acc/mode = 0, all outputs 0. The partial frame is discarded.

## Timing
- Reset values: z = 0, busy = 0, frame_done = 0, par_err = 0, err_sticky = 0, err_cnt = 0.
- z, busy: registered; they reflect the bit accepted on the previous edge.
- frame_done, par_err: registered and asserted for exactly one cycle. They appear in the cycle after the edge that accepts the parity bit (latency 1).
- err_sticky, err_cnt: update on the same edge that raises par_err.
- Back-to-back frames: the first data bit of the next frame may be accepted in the same cycle that frame_done is high.
- Minimum frame time is DATA_W+1 cycles. Gaps in x_valid are unbounded.

## Configuration
- PARITY_ERRCNT_EN defined: err_cnt is implemented as the CNT_W saturating counter described above.
- PARITY_ERRCNT_EN undefined: no counter flops are implemented and err_cnt is tied to 0. err_sticky and all other behaviour are unchanged.

## Test plan
- Reset: hold reset = 0 while toggling x/x_valid → all outputs 0. Release and send a good frame → normal check.
- Even mode, DATA_W = 8:
  - Data bits 1,0,1,1,0,0,1,0 → z ends at 0.
  - Parity bit 0 → frame_done = 1 for one cycle, par_err = 0, err_cnt = 0.
- Even mode, same data, parity bit 1 → par_err = 1 with frame_done, err_sticky = 1, err_cnt = 1.
- Odd mode latch:
  - Data 0x01, odd = 1 at first bit, odd driven 0 mid-frame, parity bit 0 → no error.
  - Same frame with parity bit 1 → error.
- Gaps and mid-frame reset:
  - x_valid low for 3 cycles between every bit → result identical to the gapless case.
  - reset = 0 after 5 bits → busy = 0, z = 0. The next full good frame passes.
- Saturation and clear (CNT_W = 2, macro defined):
  - 5 bad frames → err_cnt = 3.
  - clr alone → err_cnt = 0, err_sticky = 0.
  - clr coincident with an error → err_cnt = 1, err_sticky = 1.
  - Macro undefined → err_cnt stays 0 throughout.

Source files
------------

// File: rtl/parity_frame_chk_if.sv
// Serial bit stream and status bundle for parity_frame_chk.
// The master side feeds bits; the slave side is the checker.
interface parity_frame_chk_if #(
   parameter int unsigned CNT_W = 8
);
   logic             x;
   logic             x_valid;
   logic             odd;
   logic             clr;
   logic             z;
   logic             busy;
   logic             frame_done;
   logic             par_err;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output x, x_valid, odd, clr,
      input  z, busy, frame_done, par_err, err_sticky, err_cnt
   );

   modport slave (
      input  x, x_valid, odd, clr,
      output z, busy, frame_done, par_err, err_sticky, err_cnt
   );
endinterface

// File: rtl/parity_frame_chk.sv
// Framed serial parity checker: DATA_W data bits then one parity bit per frame.
// Define PARITY_ERRCNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module parity_frame_chk #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input logic             clk,
   input logic             reset,
   parity_frame_chk_if.slave bus
);
   localparam int unsigned CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            acc_q, acc_d;
   logic            mode_q, mode_d;
   logic            busy_q;
   logic            fd_q, fd_d;
   logic            pe_q, pe_d;
   logic            sticky_q, sticky_d;

   // State and frame registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= 1'b0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         fd_q     <= 1'b0;
         pe_q     <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mode_q   <= mode_d;
         busy_q   <= (state_d != IDLE);
         fd_q     <= fd_d;
         pe_q     <= pe_d;
         sticky_q <= sticky_d;
      end
   end

   // Next-state, parity accumulation and status pulses
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mode_d   = mode_q;
      fd_d     = 1'b0;
      pe_d     = 1'b0;
      if (bus.x_valid) begin
         unique case (state_q)
            IDLE: begin
               acc_d   = bus.x;
               mode_d  = bus.odd;
               cnt_d   = CW'(1);
               state_d = (DATA_W == 1) ? PAR : DATA;
            end
            DATA: begin
               acc_d = acc_q ^ bus.x;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_W - 1)) state_d = PAR;
            end
            PAR: begin
               fd_d    = 1'b1;
               pe_d    = (bus.x != (acc_q ^ mode_q));
               acc_d   = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      // Clear takes effect before a coincident error
      sticky_d = bus.clr ? 1'b0 : sticky_q;
      if (pe_d) sticky_d = 1'b1;
   end

   assign bus.z          = acc_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = fd_q;
   assign bus.par_err    = pe_q;
   assign bus.err_sticky = sticky_q;

`ifdef PARITY_ERRCNT_EN
   logic [CNT_W-1:0] ecnt_q, ecnt_d;

   // Saturating error counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ecnt_q <= '0;
      else        ecnt_q <= ecnt_d;
   end

   always_comb begin
      ecnt_d = bus.clr ? '0 : ecnt_q;
      if (pe_d && (ecnt_d != '1)) ecnt_d = ecnt_d + CNT_W'(1);
   end

   assign bus.err_cnt = ecnt_q;
`else
   assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_parity_frame_chk.sv
// Directed bench for parity_frame_chk: frame-level model plus hand-computed checkpoints.
module tb_parity_frame_chk;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 2;
   localparam int          CMAX   = 3;
`ifdef PARITY_ERRCNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   parity_frame_chk_if #(.CNT_W(CNT_W)) bus ();

   parity_frame_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Frame-level model: bits of the current frame held in a queue
   bit q[$];
   bit m_mode   = 1'b0;
   bit m_fd     = 1'b0;
   bit m_pe     = 1'b0;
   bit m_sticky = 1'b0;
   int m_cnt    = 0;

   function automatic int ones();
      int n = 0;
      foreach (q[i]) n += int'(q[i]);
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin : model
      bit err;
      err = 1'b0;
      if (!reset) begin
         q.delete();
         m_mode = 0; m_fd = 0; m_pe = 0; m_sticky = 0; m_cnt = 0;
      end else begin
         m_fd = 0;
         m_pe = 0;
         if (bus.x_valid) begin
            if (q.size() == 0) m_mode = bus.odd;
            if (q.size() < DATA_W) q.push_back(bus.x);
            else begin
               err = (((ones() + int'(bus.x)) % 2) != int'(m_mode));
               q.delete();
               m_fd = 1;
               m_pe = err;
            end
         end
         if (bus.clr) begin m_sticky = 0; m_cnt = 0; end
         if (err) begin
            m_sticky = 1;
            if (CNT_ON != 0) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      vec_cnt++;
      if (act != exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("z",          int'(bus.z),          ones() % 2);
      chk("busy",       int'(bus.busy),       (q.size() != 0) ? 1 : 0);
      chk("frame_done", int'(bus.frame_done), int'(m_fd));
      chk("par_err",    int'(bus.par_err),    int'(m_pe));
      chk("err_sticky", int'(bus.err_sticky), int'(m_sticky));
      chk("err_cnt",    int'(bus.err_cnt),    m_cnt);
   end

   task automatic cyc(bit v, bit b, bit o, bit c);
      bus.x_valid = v;
      bus.x       = b;
      bus.odd     = o;
      bus.clr     = c;
      @(negedge clk);
   endtask

   task automatic send_frame(logic [DATA_W-1:0] d, bit p, bit o, bit flip, int gap, bit c_par);
      for (int i = 0; i < DATA_W; i++) begin
         cyc(1'b1, d[i], (i == 0) ? o : (o ^ flip), 1'b0);
         repeat (gap) cyc(1'b0, ~d[i], ~o, 1'b0);
      end
      cyc(1'b1, p, o ^ flip, c_par);
   endtask

   localparam logic [DATA_W-1:0] D_EVEN = 8'h4D;  // sent LSB first: 1,0,1,1,0,0,1,0

   initial begin
      bus.x = 0; bus.x_valid = 0; bus.odd = 0; bus.clr = 0;
      #1 reset = 1'b0;
      @(negedge clk);

      // Inputs toggling under reset are ignored
      for (int i = 0; i < 4; i++) cyc(1'b1, i[0], 1'b1, 1'b1);
      chk("rst_z", int'(bus.z), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_err_sticky", int'(bus.err_sticky), 0);
      bus.x_valid = 0;
      #1 reset = 1'b1;
      @(negedge clk);

      // Good even frame
      for (int i = 0; i < DATA_W; i++) cyc(1'b1, D_EVEN[i], 1'b0, 1'b0);
      chk("even_z_end", int'(bus.z), 0);
      chk("even_busy", int'(bus.busy), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("even_fd", int'(bus.frame_done), 1);
      chk("even_pe", int'(bus.par_err), 0);
      chk("even_cnt", int'(bus.err_cnt), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fd_one_cycle", int'(bus.frame_done), 0);
      chk("idle_busy", int'(bus.busy), 0);

      // Bad even frame
      send_frame(D_EVEN, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("bad_pe", int'(bus.par_err), 1);
      chk("bad_fd", int'(bus.frame_done), 1);
      chk("bad_sticky", int'(bus.err_sticky), 1);
      chk("bad_cnt", int'(bus.err_cnt), CNT_ON);

      // Odd mode latched on first bit, back-to-back frames
      send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      chk("odd_good_pe", int'(bus.par_err), 0);
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      chk("odd_bad_pe", int'(bus.par_err), 1);
      chk("odd_bad_fd", int'(bus.frame_done), 1);

      // Gaps between bits
      send_frame(D_EVEN, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      chk("gap_good_pe", int'(bus.par_err), 0);
      chk("gap_good_fd", int'(bus.frame_done), 1);
      send_frame(D_EVEN, 1'b1, 1'b0, 1'b0, 3, 1'b0);
      chk("gap_bad_pe", int'(bus.par_err), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-frame discards the partial frame
      for (int i = 0; i < 5; i++) cyc(1'b1, D_EVEN[i], 1'b0, 1'b0);
      chk("mid_z_pre", int'(bus.z), 1);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_busy", int'(bus.busy), 0);
      chk("mid_z", int'(bus.z), 0);
      bus.x_valid = 0;
      #1 reset = 1'b1;
      @(negedge clk);
      send_frame(D_EVEN, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      chk("post_rst_fd", int'(bus.frame_done), 1);
      chk("post_rst_pe", int'(bus.par_err), 0);

      // Saturation and clear
      repeat (5) send_frame(D_EVEN, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("sat_cnt", int'(bus.err_cnt), CNT_ON * 3);
      chk("sat_sticky", int'(bus.err_sticky), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_cnt", int'(bus.err_cnt), 0);
      chk("clr_sticky", int'(bus.err_sticky), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) send_frame(D_EVEN, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("two_err_cnt", int'(bus.err_cnt), CNT_ON * 2);
      send_frame(D_EVEN, 1'b1, 1'b0, 1'b0, 0, 1'b1);
      chk("clr_err_cnt", int'(bus.err_cnt), CNT_ON);
      chk("clr_err_sticky", int'(bus.err_sticky), 1);

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
